// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared types and defaults for the bus arbiter
package bus_arbiter_pkg;

    localparam int BUS_ARB_NUM_REQ        = 4;
    localparam int BUS_ARB_MAX_HOLD       = 64;
    localparam int BUS_ARB_TURNAROUND_CYC = 1;

    typedef enum logic [1:0] {
        ARB_IDLE       = 2'd0,
        ARB_GRANT      = 2'd1,
        ARB_TURNAROUND = 2'd2
    } BUS_ARB_STATE_T;

    // Width of an encoded requester index; never below one bit
    function automatic int bus_arb_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - request/grant bundle between the requesters and the arbiter
interface bus_arbiter_if #(
    parameter int NUM_REQ = bus_arbiter_pkg::BUS_ARB_NUM_REQ,
    parameter int ID_W    = bus_arbiter_pkg::bus_arb_id_w(NUM_REQ)
) ();

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_valid;
    logic               timeout_pulse;

    modport master (
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_valid,
        input  timeout_pulse
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_id,
        output gnt_valid,
        output timeout_pulse
    );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// rtl/bus_arbiter_rr_picker.sv - combinational round-robin search from a pointer with a request mask
module rr_picker
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = BUS_ARB_NUM_REQ,
    parameter int ID_W    = bus_arb_id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic [NUM_REQ-1:0] mask,
    output logic [ID_W-1:0]    winner,
    output logic               valid
);

    logic [NUM_REQ-1:0] cand;
    logic [ID_W-1:0]    idx;
    int                 pos;

    // Walk upward from ptr, wrapping at NUM_REQ; the first unmasked request wins
    always_comb begin
        cand   = req & ~mask;
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        pos    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = int'(ptr) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            idx = ID_W'(pos);
            if (!valid && cand[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin bus arbiter with hold limit and turnaround; option BUS_ARB_MASTER_PRIORITY_EN
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = BUS_ARB_NUM_REQ,
    parameter int MAX_HOLD       = BUS_ARB_MAX_HOLD,
    parameter int TURNAROUND_CYC = BUS_ARB_TURNAROUND_CYC
) (
    input  logic         clk,
    input  logic         rst,
    bus_arbiter_if.slave bus
);

    localparam int ID_W   = bus_arb_id_w(NUM_REQ);
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '1;
    localparam logic [2:0]        TURN_LAST = 3'(TURNAROUND_CYC - 1);
    localparam logic [ID_W-1:0]   ID_LAST   = ID_W'(NUM_REQ - 1);
`ifdef BUS_ARB_MASTER_PRIORITY_EN
    localparam bit MASTER_PRIO = 1'b1;
`else
    localparam bit MASTER_PRIO = 1'b0;
`endif

    BUS_ARB_STATE_T       state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [ID_W-1:0]      gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [2:0]           turn_cnt_q, turn_cnt_d;
    logic [NUM_REQ-1:0]   mask_q, mask_d;
    logic                 timeout_q, timeout_d;

    logic [NUM_REQ-1:0]   rr_req;
    logic [ID_W-1:0]      rr_id;
    logic                 rr_valid;
    logic [ID_W-1:0]      pick_id;
    logic                 pick_valid;
    logic                 pick_adv;
    logic [ID_W-1:0]      next_ptr;
    logic                 hold_limited;
    logic                 take;

    // With master priority the round-robin ring only covers requesters 1..N-1
    assign rr_req = MASTER_PRIO ? (bus.req & ~NUM_REQ'(1)) : bus.req;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req     (rr_req),
        .ptr     (rr_ptr_q),
        .mask    (mask_q),
        .winner  (rr_id),
        .valid   (rr_valid)
    );

    // Choose the candidate owner; a priority master win leaves the ring pointer alone
    always_comb begin
        pick_id    = rr_id;
        pick_valid = rr_valid;
        pick_adv   = rr_valid;
        if (MASTER_PRIO && bus.req[0] && !mask_q[0]) begin
            pick_id    = '0;
            pick_valid = 1'b1;
            pick_adv   = 1'b0;
        end
        next_ptr     = (pick_id == ID_LAST) ? '0 : pick_id + 1'b1;
        hold_limited = (MAX_HOLD > 0) && !(MASTER_PRIO && (gnt_id_q == '0));
    end

    // Next-state, grant, counters and the one-shot timeout mask
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        turn_cnt_d = turn_cnt_q;
        mask_d     = mask_q;
        timeout_d  = 1'b0;
        take       = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                take = pick_valid;
            end
            ARB_GRANT: begin
                if (!bus.req[gnt_id_q]) begin
                    gnt_d      = '0;
                    turn_cnt_d = '0;
                    state_d    = ARB_TURNAROUND;
                end else if (hold_limited && (hold_cnt_q == HOLD_LAST)) begin
                    gnt_d      = '0;
                    turn_cnt_d = '0;
                    timeout_d  = 1'b1;
                    mask_d     = gnt_q;
                    state_d    = ARB_TURNAROUND;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ARB_TURNAROUND: begin
                if (turn_cnt_q == TURN_LAST) begin
                    mask_d = '0;
                    take   = pick_valid;
                    if (!pick_valid) begin
                        state_d = ARB_IDLE;
                    end
                end else begin
                    turn_cnt_d = turn_cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
        endcase
        if (take) begin
            state_d    = ARB_GRANT;
            gnt_d      = NUM_REQ'(1) << pick_id;
            gnt_id_d   = pick_id;
            hold_cnt_d = '0;
            if (pick_adv) begin
                rr_ptr_d = next_ptr;
            end
        end
    end

    // State register; reset drops the grant immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            turn_cnt_q <= '0;
            mask_q     <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            turn_cnt_q <= turn_cnt_d;
            mask_q     <= mask_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.gnt           = gnt_q;
    assign bus.gnt_id        = gnt_id_q;
    assign bus.gnt_valid     = |gnt_q;
    assign bus.timeout_pulse = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter; honours BUS_ARB_MASTER_PRIORITY_EN
module tb_bus_arbiter;

    localparam int N    = 4;
    localparam int NDUT = 2;
`ifdef BUS_ARB_MASTER_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    int           checks   = 0;
    int           failures = 0;
    int           cycle    = 0;

    always #5 clk = ~clk;

    bus_arbiter_if #(.NUM_REQ(N)) ifc0 ();
    bus_arbiter_if #(.NUM_REQ(N)) ifc1 ();
    assign ifc0.req = req;
    assign ifc1.req = req;

    bus_arbiter #(.NUM_REQ(N), .MAX_HOLD(64), .TURNAROUND_CYC(1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (ifc0)
    );

    bus_arbiter #(.NUM_REQ(N), .MAX_HOLD(4), .TURNAROUND_CYC(3)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (ifc1)
    );

    function automatic int mh_of(input int k);
        return (k == 0) ? 64 : 4;
    endfunction

    function automatic int ta_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Model: current owner (-1 none), cycles held, turnaround cycles left, ring pointer, banned requester
    int m_own  [NDUT] = '{-1, -1};
    int m_held [NDUT] = '{0, 0};
    int m_gap  [NDUT] = '{0, 0};
    int m_ptr  [NDUT] = '{0, 0};
    int m_ban  [NDUT] = '{-1, -1};
    int m_last [NDUT] = '{0, 0};
    bit m_to   [NDUT] = '{1'b0, 1'b0};

    task automatic model_arbitrate(input int k, input logic [N-1:0] r, input int ban);
        m_own[k] = -1;
        if (PRIO && bit'(r) && ban != 0) begin
            m_own[k] = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                int c;
                c = (m_ptr[k] + i) % N;
                if (m_own[k] < 0 && bit'(r >> c) && c != ban && !(PRIO && c == 0)) begin
                    m_own[k] = c;
                    m_ptr[k] = (c + 1) % N;
                end
            end
        end
        if (m_own[k] >= 0) begin
            m_held[k] = 0;
            m_last[k] = m_own[k];
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            for (int k = 0; k < NDUT; k++) begin
                if (rst) begin
                    m_own[k] = -1; m_held[k] = 0; m_gap[k] = 0;
                    m_ptr[k] = 0;  m_ban[k] = -1; m_last[k] = 0; m_to[k] = 1'b0;
                end else begin
                    m_to[k] = 1'b0;
                    if (m_own[k] >= 0) begin
                        m_held[k] = m_held[k] + 1;
                        if (!bit'(req >> m_own[k])) begin
                            m_own[k] = -1;
                            m_gap[k] = ta_of(k);
                        end else if (m_held[k] >= mh_of(k) && !(PRIO && m_own[k] == 0)) begin
                            m_to[k]  = 1'b1;
                            m_ban[k] = m_own[k];
                            m_own[k] = -1;
                            m_gap[k] = ta_of(k);
                        end
                    end else if (m_gap[k] > 0) begin
                        m_gap[k] = m_gap[k] - 1;
                        if (m_gap[k] == 0) begin
                            model_arbitrate(k, req, m_ban[k]);
                            m_ban[k] = -1;
                        end
                    end else begin
                        model_arbitrate(k, req, -1);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s dut=%0d cycle=%0d got=%0h exp=%0h", name, k, cycle, got, exp);
        end
    endtask

    function automatic logic [N-1:0] gnt_of(input int k);
        return (k == 0) ? ifc0.gnt : ifc1.gnt;
    endfunction

    // Compare every DUT output against the model on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            cycle++;
            for (int k = 0; k < NDUT; k++) begin
                check("gnt", k, 32'(gnt_of(k)), (m_own[k] >= 0) ? (32'd1 << m_own[k]) : 32'd0);
                check("gnt_id", k, 32'((k == 0) ? ifc0.gnt_id : ifc1.gnt_id), 32'(m_last[k]));
                check("gnt_valid", k, 32'((k == 0) ? ifc0.gnt_valid : ifc1.gnt_valid), 32'(m_own[k] >= 0));
                check("timeout", k, 32'((k == 0) ? ifc0.timeout_pulse : ifc1.timeout_pulse), 32'(m_to[k]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int           order [$];
    int           gaps  [$];
    int           exp_order [5] = '{0, 1, 2, 3, 0};
    int           own_cyc;
    int           zero_run;
    logic         prev_valid;
    logic [N-1:0] g1 [11];
    logic         t1 [11];
    int           gap_cnt [NDUT];
    bit           seen [NDUT];
    int           to_cnt;

    initial begin
        rst = 1'b1;
        req = '0;
        tick(3);
        check("reset_gnt", 0, 32'(ifc0.gnt), 32'd0);
        check("reset_id", 1, 32'(ifc1.gnt_id), 32'd0);
        rst = 1'b0;
        tick(1);

        // All four request; each owner lets go after three grant cycles
        req = 4'b1111; own_cyc = 0; zero_run = 0; prev_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ifc0.gnt_valid) begin
                if (!prev_valid) begin
                    order.push_back(int'(ifc0.gnt_id));
                    if (order.size() > 1) gaps.push_back(zero_run);
                    own_cyc = 0;
                end
                own_cyc++;
                req = (own_cyc == 3) ? (4'b1111 & ~ifc0.gnt) : 4'b1111;
                zero_run = 0;
            end else begin
                req = 4'b1111;
                zero_run++;
            end
            prev_valid = ifc0.gnt_valid;
        end
        check("rr_count", 0, 32'(order.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check("rr_order", 0, (i < order.size()) ? 32'(order[i]) : 32'hffff_ffff, 32'(exp_order[i]));
        end
        for (int i = 0; i < 4; i++) begin
            check("rr_gap", 0, (i < gaps.size()) ? 32'(gaps[i]) : 32'hffff_ffff, 32'd1);
        end
        req = '0;
        tick(8);

        // Single requester 2: grant one cycle later, release, idle with id kept
        req = 4'b0100;
        tick(1);
        check("single_gnt", 0, 32'(ifc0.gnt), 32'h4);
        check("single_id", 0, 32'(ifc0.gnt_id), 32'd2);
        tick(4);
        req = '0;
        tick(1);
        check("single_drop", 0, 32'(ifc0.gnt), 32'd0);
        tick(1);
        check("single_keep_id", 0, 32'(ifc0.gnt_id), 32'd2);
        tick(6);

        // Hold limit of four cycles on dut1, then regrant after two arbitration points
        req = 4'b0010;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            g1[c] = ifc1.gnt;
            t1[c] = ifc1.timeout_pulse;
        end
        check("to_gnt_c1", 1, 32'(g1[1]), 32'h2);
        check("to_gnt_c4", 1, 32'(g1[4]), 32'h2);
        check("to_gnt_c5", 1, 32'(g1[5]), 32'h0);
        check("to_pulse_c5", 1, 32'(t1[5]), 32'd1);
        check("to_pulse_c6", 1, 32'(t1[6]), 32'd0);
        check("to_gnt_c8", 1, 32'(g1[8]), 32'h0);
        check("to_regrant_c9", 1, 32'(g1[9]), 32'h2);
        req = '0;
        tick(8);

        // Handover: 0 drops while 1 rises in the same cycle
        req = 4'b0001;
        tick(2);
        req = 4'b0010;
        gap_cnt = '{0, 0};
        seen    = '{1'b0, 1'b0};
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) begin
                if (!seen[k]) begin
                    if (gnt_of(k) == 4'b0010) seen[k] = 1'b1;
                    else if (gnt_of(k) == 4'b0000) gap_cnt[k]++;
                end
            end
        end
        check("handover_seen", 0, 32'(seen[0]), 32'd1);
        check("handover_gap", 0, 32'(gap_cnt[0]), 32'd1);
        check("handover_seen", 1, 32'(seen[1]), 32'd1);
        check("handover_gap", 1, 32'(gap_cnt[1]), 32'd3);
        req = '0;
        tick(8);

        // Reset mid-tenure drops the grant without a clock edge
        req = 4'b1000;
        tick(2);
        #2 rst = 1'b1;
        #1;
        check("async_rst_gnt", 0, 32'(ifc0.gnt), 32'd0);
        check("async_rst_gnt", 1, 32'(ifc1.gnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0001;
        tick(1);
        check("post_rst_gnt", 0, 32'(ifc0.gnt), 32'h1);
        check("post_rst_id", 0, 32'(ifc0.gnt_id), 32'd0);
        req = '0;
        tick(6);

`ifdef BUS_ARB_MASTER_PRIORITY_EN
        req = 4'b1000;
        tick(2);
        req = 4'b1001;
        tick(2);
        req = 4'b0001;
        to_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            to_cnt = to_cnt + int'(ifc0.timeout_pulse) + int'(ifc1.timeout_pulse);
        end
        check("prio_no_timeout", 1, 32'(to_cnt), 32'd0);
        check("prio_owner", 1, 32'(ifc1.gnt), 32'h1);
        req = '0;
        tick(6);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
